// File: rtl/fpu_round_pkg.sv
// Shared definitions for the FPU rounding scheduler.
//   FRAC_IN_W / FRAC_OUT_W : fraction widths before (xx.47) and after (xx.30) rounding
//   SRC_ADD / SRC_MUL      : source encoding (add/sub pipe = 0, mul/div pipe = 1)
//   round_req_t            : one rounding request; the tag travels separately
//                            because its width is a module parameter.
package fpu_round_pkg;

  localparam int FRAC_IN_W  = 49;
  localparam int FRAC_OUT_W = 32;

  localparam logic SRC_ADD = 1'b0;
  localparam logic SRC_MUL = 1'b1;

  typedef struct packed {
    logic                 mode;
    logic                 sticky;
    logic [FRAC_IN_W-1:0] fraction;
  } round_req_t;

endpackage

// File: rtl/rounding_rr_arbiter.sv
// Two-way round-robin arbiter.
//   clk, reset_n : clock, synchronous active-low reset
//   valid[1:0]   : per-source request valid
//   advance      : a handshake happens this cycle with the granted source
//   grant[1:0]   : one-hot grant (zero when nothing is valid)
//   ptr          : preferred source when both are valid
module rounding_rr_arbiter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  // After serving source i the other source becomes preferred, so the
  // new pointer is simply "source 0 was just served".
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/rounding_unit_scheduler.sv
// Scheduler and two-stage pipeline controller for the shared rounding datapath.
//   req_valid/req_ready[1:0]         : per-source request handshake
//   req_mode/req_sticky[1:0]         : per-source mode and sticky bits
//   req_fraction0/1, req_tag0/1      : per-source fraction (xx.47) and tag
//   rnd_mode/rnd_sticky/rnd_fraction : stage-1 request to the external datapath
//   rnd_result                       : combinational rounded fraction (xx.30)
//   out_valid/out_ready              : result handshake
//   out_fraction/out_source/out_tag  : registered result
//   in_flight                        : number of occupied stages (0..2)
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. A producer holds valid and its payload stable until
// that edge; ready may depend combinationally on valid, valid never on ready.
module rounding_unit_scheduler
  import fpu_round_pkg::*;
#(
  parameter int TAG_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_mode,
  input  logic [1:0]            req_sticky,
  input  logic [FRAC_IN_W-1:0]  req_fraction0,
  input  logic [FRAC_IN_W-1:0]  req_fraction1,
  input  logic [TAG_WIDTH-1:0]  req_tag0,
  input  logic [TAG_WIDTH-1:0]  req_tag1,
  output logic                  rnd_mode,
  output logic                  rnd_sticky,
  output logic [FRAC_IN_W-1:0]  rnd_fraction,
  input  logic [FRAC_OUT_W-1:0] rnd_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FRAC_OUT_W-1:0] out_fraction,
  output logic                  out_source,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [1:0]            in_flight
);

  // Stage 1: request presented to the datapath
  logic                  s1_valid;
  round_req_t            s1_req;
  logic                  s1_source;
  logic [TAG_WIDTH-1:0]  s1_tag;

  // Stage 2: captured result
  logic                  s2_valid;
  logic [FRAC_OUT_W-1:0] s2_fraction;
  logic                  s2_source;
  logic [TAG_WIDTH-1:0]  s2_tag;

  logic                  s2_load;
  logic                  accept;
  logic                  handshake;
  logic [1:0]            grant;
  logic                  ptr;
  logic                  hs_source;
  round_req_t            hs_req;
  logic [TAG_WIDTH-1:0]  hs_tag;

  // S2 can take S1 when it is empty or draining this cycle; S1 can take a
  // new request when it is empty or moving into S2. This chain lets a pop,
  // shift and push all happen on the same edge.
  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign accept    = !s1_valid || s2_load;
  assign req_ready = grant & {2{accept}};
  assign handshake = |req_ready;

  rounding_rr_arbiter u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (req_valid),
    .advance (handshake),
    .grant   (grant),
    .ptr     (ptr)
  );

  // Request mux for the granted source
  always_comb begin
    hs_source = req_ready[1] ? SRC_MUL : SRC_ADD;
    if (hs_source == SRC_MUL) begin
      hs_req = '{mode: req_mode[1], sticky: req_sticky[1], fraction: req_fraction1};
      hs_tag = req_tag1;
    end else begin
      hs_req = '{mode: req_mode[0], sticky: req_sticky[0], fraction: req_fraction0};
      hs_tag = req_tag0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_req    <= '0;
      s1_source <= 1'b0;
      s1_tag    <= '0;
    end else if (handshake) begin
      s1_valid  <= 1'b1;
      s1_req    <= hs_req;
      s1_source <= hs_source;
      s1_tag    <= hs_tag;
    end else if (accept) begin
      s1_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid    <= 1'b0;
      s2_fraction <= '0;
      s2_source   <= 1'b0;
      s2_tag      <= '0;
    end else if (s2_load) begin
      s2_valid    <= 1'b1;
      s2_fraction <= rnd_result;
      s2_source   <= s1_source;
      s2_tag      <= s1_tag;
    end else if (out_ready) begin
      s2_valid    <= 1'b0;
    end
  end

  assign rnd_mode     = s1_req.mode;
  assign rnd_sticky   = s1_req.sticky;
  assign rnd_fraction = s1_req.fraction;

  assign out_valid    = s2_valid;
  assign out_fraction = s2_fraction;
  assign out_source   = s2_source;
  assign out_tag      = s2_tag;

  assign in_flight    = {1'b0, s1_valid} + {1'b0, s2_valid};

endmodule

// File: tb/tb_rounding_unit_scheduler.sv
// Self-checking bench for rounding_unit_scheduler. Inputs change 1 time unit
// after the rising edge; all observation happens on the falling edge.
module tb_rounding_unit_scheduler;

  localparam int TW = 4;
  localparam int EW = 1 + TW + 32;   // {source, tag, fraction}

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_mode;
  logic [1:0]    req_sticky;
  logic [48:0]   req_fraction0;
  logic [48:0]   req_fraction1;
  logic [TW-1:0] req_tag0;
  logic [TW-1:0] req_tag1;
  logic          rnd_mode;
  logic          rnd_sticky;
  logic [48:0]   rnd_fraction;
  logic [31:0]   rnd_result;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_fraction;
  logic          out_source;
  logic [TW-1:0] out_tag;
  logic [1:0]    in_flight;

  int tests_run    = 0;
  int tests_failed = 0;
  int n_out        = 0;

  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  rounding_unit_scheduler #(.TAG_WIDTH(TW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_mode      (req_mode),
    .req_sticky    (req_sticky),
    .req_fraction0 (req_fraction0),
    .req_fraction1 (req_fraction1),
    .req_tag0      (req_tag0),
    .req_tag1      (req_tag1),
    .rnd_mode      (rnd_mode),
    .rnd_sticky    (rnd_sticky),
    .rnd_fraction  (rnd_fraction),
    .rnd_result    (rnd_result),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_fraction  (out_fraction),
    .out_source    (out_source),
    .out_tag       (out_tag),
    .in_flight     (in_flight)
  );

  // Bench rounding datapath: drop 17 fraction bits, increment when the
  // mode bit is set and the guard or sticky bit is set.
  function automatic logic [31:0] round_model(input logic mode, input logic sticky,
                                              input logic [48:0] frac);
    return frac[48:17] + {31'b0, mode & (sticky | frac[16])};
  endfunction

  assign rnd_result = round_model(rnd_mode, rnd_sticky, rnd_fraction);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on request handshake, pop on output handshake.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_out", {out_source, out_tag, out_fraction}, '0);
        end else begin
          check("sb_out", {27'b0, out_source, out_tag, out_fraction}, {27'b0, exp_q.pop_front()});
        end
      end
      if (req_valid[0] && req_ready[0])
        exp_q.push_back({1'b0, req_tag0, round_model(req_mode[0], req_sticky[0], req_fraction0)});
      if (req_valid[1] && req_ready[1])
        exp_q.push_back({1'b1, req_tag1, round_model(req_mode[1], req_sticky[1], req_fraction1)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req(input int src);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if (src == 0) begin
      req_fraction0 = r[48:0];
      req_tag0      = TW'($urandom_range(0, 15));
      req_mode[0]   = 1'($urandom_range(0, 1));
      req_sticky[0] = 1'($urandom_range(0, 1));
    end else begin
      req_fraction1 = r[48:0];
      req_tag1      = TW'($urandom_range(0, 15));
      req_mode[1]   = 1'($urandom_range(0, 1));
      req_sticky[1] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    req_valid = 2'b00;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_flight == 2'd0 && exp_q.size() == 0) done = 1'b1;
      else step();
    end
    check("drain_done", {63'b0, done}, 64'd1);
    step();
  endtask

  initial begin
    logic [EW-1:0] snap;
    int cnt0, cnt1, sent, n_base;
    logic exp_s;
    logic [1:0] g;

    reset_n = 1'b0;
    out_ready = 1'b0;
    req_valid = 2'b00;
    req_mode = 2'b00;
    req_sticky = 2'b00;
    rand_req(0);
    rand_req(1);
    repeat (3) step();

    // Reset state
    @(negedge clk);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_in_flight", {62'b0, in_flight}, 64'd0);
    check("rst_req_ready", {62'b0, req_ready}, 64'd0);
    check("rst_ptr", {63'b0, dut.u_arb.ptr}, 64'd0);
    check("rst_rnd_fraction", {15'b0, rnd_fraction}, 64'd0);
    check("rst_out_data", {27'b0, out_source, out_tag, out_fraction}, 64'd0);

    // Simultaneous requests
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    req_tag0 = 4'd3;
    req_tag1 = 4'd5;
    req_valid = 2'b11;
    @(negedge clk);
    check("sim_ready_c0", {62'b0, req_ready}, 64'h1);
    step();
    req_valid = 2'b10;
    @(negedge clk);
    check("sim_ready_c1", {62'b0, req_ready}, 64'h2);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    check("sim_out_c2", {59'b0, out_valid, out_source, out_tag}, {59'b0, 1'b1, 1'b0, 4'd3});
    step();
    @(negedge clk);
    check("sim_out_c3", {59'b0, out_valid, out_source, out_tag}, {59'b0, 1'b1, 1'b1, 4'd5});
    drain();

    // Fairness
    cnt0 = 0;
    cnt1 = 0;
    exp_s = 1'b0;
    rand_req(0);
    rand_req(1);
    req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      g = req_ready;
      check("fair_grant", {62'b0, g}, exp_s ? 64'h2 : 64'h1);
      if (g[0]) cnt0++;
      if (g[1]) cnt1++;
      step();
      if (g[0]) rand_req(0);
      if (g[1]) rand_req(1);
      exp_s = ~exp_s;
    end
    check("fair_cnt0", 64'(cnt0), 64'd4);
    check("fair_cnt1", 64'(cnt1), 64'd4);
    drain();

    // Data path through source 1
    req_fraction1 = 49'h1_0000_0002_0000;
    req_mode[1] = 1'b0;
    req_sticky[1] = 1'b0;
    req_tag1 = 4'd9;
    req_valid = 2'b10;
    @(negedge clk);
    check("dp_ready", {62'b0, req_ready}, 64'h2);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    check("dp_rnd_fraction", {15'b0, rnd_fraction}, 64'h1_0000_0002_0000);
    step();
    @(negedge clk);
    check("dp_out", {30'b0, out_valid, out_source, out_fraction}, {30'b0, 1'b1, 1'b1, 32'h8000_0001});
    drain();

    // Backpressure with stall stability
    out_ready = 1'b0;
    sent = 0;
    snap = '0;
    n_base = n_out;
    rand_req(0);
    for (int k = 0; k < 5; k++) begin
      req_valid = (sent < 3) ? 2'b01 : 2'b00;
      @(negedge clk);
      if (k >= 2) begin
        check("bp_ready_full", {62'b0, req_ready}, 64'h0);
        check("bp_out_valid", {63'b0, out_valid}, 64'd1);
      end
      if (k == 2) snap = {out_source, out_tag, out_fraction};
      if (k > 2) check("stall_stable", {27'b0, out_source, out_tag, out_fraction}, {27'b0, snap});
      if (k == 4) check("bp_in_flight", {62'b0, in_flight}, 64'd2);
      g = req_ready;
      step();
      if (g[0]) begin
        sent++;
        rand_req(0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_push", {62'b0, req_ready}, 64'h1);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    check("bp_next_out", {63'b0, out_valid}, 64'd1);
    step();
    @(negedge clk);
    check("bp_last_out", {63'b0, out_valid}, 64'd1);
    drain();
    check("bp_out_count", 64'(n_out - n_base), 64'd3);

    // Reset mid-operation
    out_ready = 1'b0;
    rand_req(0);
    req_valid = 2'b01;
    step();
    rand_req(0);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    check("mid_in_flight_pre", {62'b0, in_flight}, 64'd2);
    check("mid_ptr_pre", {63'b0, dut.u_arb.ptr}, 64'd1);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_out_valid", {63'b0, out_valid}, 64'd0);
    check("mid_in_flight", {62'b0, in_flight}, 64'd0);
    check("mid_ptr", {63'b0, dut.u_arb.ptr}, 64'd0);
    step();
    out_ready = 1'b1;
    rand_req(0);
    rand_req(1);
    req_valid = 2'b11;
    @(negedge clk);
    check("mid_first_grant", {62'b0, req_ready}, 64'h1);
    step();
    req_valid = 2'b10;
    @(negedge clk);
    check("mid_second_grant", {62'b0, req_ready}, 64'h2);
    step();
    drain();

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
